// File: rtl/mic_array_pkg.sv
// Board-level constants shared across the mic-array design.
package mic_array_pkg;
  localparam int unsigned CLK_HZ            = 50_000_000;
  localparam int unsigned DEBOUNCE_CNT_W    = 18;
  localparam int unsigned LONG_PRESS_CYCLES = CLK_HZ;
endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: polarity fix, 2-flop sync, stability window,
// debounced level plus press/release/long-press pulses.
module debounce_channel #(
  parameter int unsigned CNT_W       = 18,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter logic        INVERT      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pb_out,
  output logic pb_next,
  output logic press,
  output logic released,
  output logic long_press
);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

  logic              pin;
  logic              sync_a;
  logic              sync_b;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [HOLD_W-1:0] hold;

  assign pin = pb_in ^ INVERT;

  // Counter wraps to zero by itself on the cycle the new level is accepted.
  always_comb begin
    pb_next  = pb_out;
    cnt_next = '0;
    if (sync_b != pb_out) begin
      cnt_next = cnt + 1'b1;
      if (&cnt) pb_next = sync_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      cnt        <= '0;
      hold       <= '0;
      pb_out     <= 1'b0;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
    end else begin
      sync_a     <= pin;
      sync_b     <= sync_a;
      cnt        <= cnt_next;
      pb_out     <= pb_next;
      press      <= pb_next & ~pb_out;
      released   <= ~pb_next & pb_out;
      // hold stays 0 on the press edge and counts only across held cycles
      if (!(pb_next && pb_out)) hold <= '0;
      else if (hold != HOLD_MAX) hold <= hold + 1'b1;
      long_press <= pb_next && pb_out && (hold == HOLD_PRE);
    end
  end
endmodule

// File: rtl/button_debouncer_multi.sv
// N_CH independent debounced push buttons with event pulses and a
// registered any-pressed flag.
module button_debouncer_multi
  import mic_array_pkg::*;
#(
  parameter int unsigned     N_CH        = 4,
  parameter int unsigned     CNT_W       = DEBOUNCE_CNT_W,
  parameter int unsigned     HOLD_CYCLES = LONG_PRESS_CYCLES,
  parameter logic [N_CH-1:0] INVERT      = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_out,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] long_press,
  output logic            any_pressed
);
  logic [N_CH-1:0] pb_next;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .HOLD_CYCLES(HOLD_CYCLES),
      .INVERT     (INVERT[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .pb_in     (pb_in[i]),
      .pb_out    (pb_out[i]),
      .pb_next   (pb_next[i]),
      .press     (press[i]),
      .released  (released[i]),
      .long_press(long_press[i])
    );
  end

  // Built from next-state levels so it moves on the same edge as pb_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_pressed <= 1'b0;
    else     any_pressed <= |pb_next;
  end
endmodule

// File: tb/tb_button_debouncer_multi.sv
// Randomized and directed bench for button_debouncer_multi against a
// cycle-level behavioural model of the debounce rules.
module tb_button_debouncer_multi;
  localparam int unsigned N   = 2;
  localparam int unsigned CW  = 3;
  localparam int unsigned HC  = 20;
  localparam int unsigned WIN = 1 << CW;
  localparam logic [1:0]  INV = 2'b10;
  localparam logic [1:0]  IDLE = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] pb_in = IDLE;
  logic [1:0] pb_out, press, released, long_press;
  logic       any_pressed;

  always #5 clk = ~clk;

  button_debouncer_multi #(
    .N_CH(N), .CNT_W(CW), .HOLD_CYCLES(HC), .INVERT(INV)
  ) dut (
    .clk(clk), .rst(rst), .pb_in(pb_in), .pb_out(pb_out), .press(press),
    .released(released), .long_press(long_press), .any_pressed(any_pressed)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pins seen two edges late; level flips after WIN
  // consecutive disagreeing samples; long press after HC held cycles.
  logic [1:0] m_pin1 = '0, m_pin2 = '0;
  logic [1:0] m_pb = '0, m_press = '0, m_rel = '0, m_long = '0;
  logic       m_any = 1'b0;
  int         m_run[2] = '{0, 0};
  int         m_held[2] = '{0, 0};

  always @(posedge clk or posedge rst) begin : model
    logic [1:0] pin;
    logic [1:0] seen;
    if (rst) begin
      m_pin1 = '0; m_pin2 = '0; m_pb = '0; m_press = '0; m_rel = '0;
      m_long = '0; m_any = 1'b0;
      m_run = '{0, 0}; m_held = '{0, 0};
    end else begin
      pin  = pb_in ^ INV;
      seen = m_pin2;
      m_pin2 = m_pin1;
      m_pin1 = pin;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int ch = 0; ch < 2; ch++) begin
        if (seen[ch] != m_pb[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == WIN) begin
            m_run[ch] = 0;
            m_pb[ch] = seen[ch];
            if (seen[ch]) m_press[ch] = 1'b1;
            else          m_rel[ch] = 1'b1;
          end
        end else begin
          m_run[ch] = 0;
        end
        if (!m_pb[ch] || m_press[ch]) m_held[ch] = 0;
        else if (m_held[ch] < HC) begin
          m_held[ch]++;
          if (m_held[ch] == HC) m_long[ch] = 1'b1;
        end
      end
      m_any = |m_pb;
    end
  end

  int press_cnt[2], rel_cnt[2], long_cnt[2];

  always @(negedge clk) begin
    check_eq("pb_out", 32'(pb_out), 32'(m_pb));
    check_eq("press", 32'(press), 32'(m_press));
    check_eq("release", 32'(released), 32'(m_rel));
    check_eq("long_press", 32'(long_press), 32'(m_long));
    check_eq("any_pressed", 32'(any_pressed), 32'(m_any));
    for (int ch = 0; ch < 2; ch++) begin
      press_cnt[ch] += int'(press[ch]);
      rel_cnt[ch]   += int'(released[ch]);
      long_cnt[ch]  += int'(long_press[ch]);
    end
  end

  task automatic clear_counts();
    press_cnt = '{0, 0}; rel_cnt = '{0, 0}; long_cnt = '{0, 0};
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 press, 1 release, 2 long press; n = 0 means the bound expired
  task automatic wait_pulse(input int ch, input int kind, output int n);
    logic hit;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      hit = (kind == 0) ? press[ch] : (kind == 1) ? released[ch] : long_press[ch];
      if (hit) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    tick(3);
    rst = 1'b0;
    clear_counts();
    tick(40);
    check_eq("idle_after_reset", 32'(press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1] + long_cnt[0] + long_cnt[1]), 0);

    // clean press / release on ch0
    pb_in[0] = 1'b1;
    wait_pulse(0, 0, n);
    check_eq("press_latency", 32'(n), 32'(2 + WIN));
    check_eq("pb_out0_high", 32'(pb_out[0]), 1);
    tick(1);
    check_eq("press_one_cycle", 32'(press[0]), 0);
    tick(4);
    pb_in[0] = 1'b0;
    wait_pulse(0, 1, n);
    check_eq("release_latency", 32'(n), 32'(2 + WIN));

    // reset while ch0 is pressed clears outputs immediately
    pb_in[0] = 1'b1;
    wait_pulse(0, 0, n);
    tick(3);
    rst = 1'b1;
    #1;
    check_eq("rst_async_outs", 32'({pb_out, press, released, long_press, any_pressed}), 0);
    tick(2);
    pb_in = IDLE;
    rst = 1'b0;
    clear_counts();
    tick(40);
    check_eq("no_pulse_after_rst", 32'(press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1] + long_cnt[0] + long_cnt[1]), 0);

    // glitch rejection on ch0
    clear_counts();
    pb_in[0] = 1'b1; tick(WIN - 1);
    pb_in[0] = 1'b0; tick(1);
    pb_in[0] = 1'b1; tick(WIN - 1);
    pb_in[0] = 1'b0; tick(20);
    check_eq("glitch_no_press", 32'(press_cnt[0] + rel_cnt[0]), 0);

    // long press on active-low ch1
    clear_counts();
    pb_in[1] = 1'b0;
    wait_pulse(1, 0, n);
    check_eq("press1_latency", 32'(n), 32'(2 + WIN));
    wait_pulse(1, 2, n);
    check_eq("long_latency", 32'(n), 32'(HC));
    tick(100 - HC);
    check_eq("long_once", 32'(long_cnt[1]), 1);
    pb_in[1] = 1'b1;
    tick(20);
    clear_counts();
    pb_in[1] = 1'b0;
    wait_pulse(1, 0, n);
    tick(5);
    pb_in[1] = 1'b1;
    tick(25);
    check_eq("short_hold_no_long", 32'(long_cnt[1]), 0);
    check_eq("short_hold_release", 32'(rel_cnt[1]), 1);

    // simultaneous channels
    pb_in = 2'b01;
    wait_pulse(0, 0, n);
    check_eq("simul_press", 32'(press), 32'h3);
    check_eq("simul_any", 32'(any_pressed), 1);
    pb_in = 2'b00;
    wait_pulse(0, 1, n);
    check_eq("rel0_any_holds", 32'({pb_out, any_pressed}), 32'b101);
    pb_in = IDLE;
    tick(20);

    // reset mid-count restarts the window
    pb_in[0] = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_counts();
    wait_pulse(0, 0, n);
    check_eq("rst_midcount_latency", 32'(n), 32'(2 + WIN));
    tick(20);
    check_eq("rst_midcount_once", 32'(press_cnt[0]), 1);
    pb_in = IDLE;
    tick(20);

    // random pin activity, checked cycle by cycle against the model
    for (int k = 0; k < 150; k++) begin
      pb_in = 2'($urandom);
      if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(25, 60)));
      else tick(int'($urandom_range(1, 12)));
    end
    pb_in = IDLE;
    tick(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_debouncer_multi.md
# button_debouncer_multi

Debounces `N_CH` independent raw push-button inputs. Each channel has a per-channel polarity option and a parametrised stability window. Alongside the debounced level, each channel produces one-cycle press, release and long-press event pulses. The block sits between the board push-button pins and the control logic in the mic-array design, replacing per-button single-channel debouncer instances.

## Interface
- `N_CH`, default 4: number of button channels.
- `CNT_W`, default 18: stability counter width. An input change must persist for 2^CNT_W clocks, which is 5.24 ms at 50 MHz.
- `HOLD_CYCLES`, default 50_000_000: pressed duration that triggers `long_press`, which is 1 s at 50 MHz. Must be ≥ 2.
- `INVERT`, default 0: `N_CH`-bit mask. A set bit marks that channel's pin as active-low.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pb_in`  in  N_CH  raw asynchronous button pins.
- `pb_out`  out  N_CH  debounced level, 1 = pressed after polarity correction.
- `press`  out  N_CH  one-cycle pulse when `pb_out[i]` goes 0→1.
- `release`  out  N_CH  one-cycle pulse when `pb_out[i]` goes 1→0.
- `long_press`  out  N_CH  one-cycle pulse, at most once per press.
- `any_pressed`  out  1  registered OR of `pb_out`.

## Operation
- **Per channel, input path:** `pin_i = pb_in[i] ^ INVERT[i]`. This goes into a 2-flop synchronizer whose flops reset to 0; its output is `sync_i`.
- **Stability counter `cnt_i`:**
  - `cnt_i` is `CNT_W` bits wide.
  - If `sync_i == pb_out[i]`, `cnt_i <= 0`.
  - Otherwise `cnt_i <= cnt_i + 1`. If `cnt_i` is all ones in that cycle, `pb_out[i] <= sync_i` and `cnt_i` wraps to 0.
  - Any single cycle of agreement restarts the window, so glitches shorter than 2^CNT_W clocks never reach `pb_out`.
- **Edge pulses:**
  - `press[i]` and `release[i]` are registered on the same edge that updates `pb_out[i]`.
  - Each is high for exactly the one cycle in which `pb_out[i]` first shows the new value.
  - `press[i]` and `release[i]` are never high together.
- **Hold counter `hold_i`:**
  - Width is `$clog2(HOLD_CYCLES+1)`.
  - It is 0 while `pb_out[i]==0` and on the press edge.
  - While `pb_out[i]==1` it increments, saturating at `HOLD_CYCLES`.
  - `long_press[i]` pulses in the cycle in which `hold_i` reaches `HOLD_CYCLES`. It does not repeat while held.
  - A release before then produces no `long_press`.
- **Channels** are fully independent. Simultaneous events on different channels each produce their own pulses in the same cycle.
- **`any_pressed`** is registered from the next-state value of `pb_out`, so it changes on the same edge as `pb_out`.

## Timing
- **Reset values:** while `rst` is high, asynchronously set:
  - `pb_out`, `press`, `release`, `long_press`, `any_pressed` to 0;
  - all `cnt_i`, `hold_i` and synchronizer flops to 0.
- **Reset mid-operation:** any pending event is discarded. After release of reset, an active-low pin sitting idle-high is seen as released and generates no spurious pulse.
- **Pin-to-output latency:** for a clean pin step, `pb_out` changes 2 + 2^CNT_W clocks after the first edge that samples the new pin level. `press`/`release` appear in that same cycle.
- **Long-press timing:** `long_press` asserts exactly `HOLD_CYCLES` clocks after the `press` pulse cycle.
- **Hold counter reset on release:** a release and a re-press separated by the debounce window restart `hold_i` from 0.

## Structure
- **Shared package `mic_array_pkg`:**
  - `CLK_HZ = 50_000_000`;
  - `DEBOUNCE_CNT_W = 18`;
  - `LONG_PRESS_CYCLES = CLK_HZ`.
  - The top-level instance takes its parameters from these.
- **Sub-module `debounce_channel`:** contains one channel's inversion, synchronizer, `cnt`, `hold`, `pb_out` and pulse registers. It is instantiated `N_CH` times in a generate loop. The top level contains only the generate loop and the `any_pressed` register.

## Test plan
Bench parameters: `N_CH=2`, `CNT_W=3`, `HOLD_CYCLES=20`, `INVERT=2'b10`.

- **Reset:** assert `rst` mid-cycle with `pb_in=2'b10` held. All outputs go 0 immediately. After deassertion, with 40 idle cycles, no pulses occur.
- **Clean press/release, ch0:** drive `pb_in[0]` 0→1 and hold. `pb_out[0]` and `press[0]` go high 10 clocks later, with `press` high for 1 cycle. Then drive 1→0. `release[0]` pulses 10 clocks later.
- **Glitch rejection:** drive ch0 high for 7 cycles, low for 1, high for 7, then low. `pb_out[0]` stays 0 and no pulses occur.
- **Long press, ch1 (active-low):** drive `pb_in[1]` low and hold. `press[1]` fires, then `long_press[1]` fires 20 clocks later, exactly once over 100 held cycles. A release after a 15-cycle hold produces no `long_press`.
- **Simultaneous channels:** step both pins to pressed on the same clock. `press` = 2'b11 in one cycle and `any_pressed` rises on the same edge. Release ch0 only: `any_pressed` stays 1.
- **Reset mid-count:** assert `rst` 5 cycles into a pending press. On deassertion with the pin still pressed, the full 10-cycle latency is counted afresh and `press` fires once.
